// File: rtl/mpu_pkg.sv
// ============================================================================
// mpu_pkg : shared arbiter state encodings and counter saturation constant
// Revision: 1.0
// ============================================================================
`default_nettype none

package mpu_pkg;

  localparam logic [0:0] c_state_idle = 1'b0;
  localparam logic [0:0] c_state_full = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = c_state_idle,
    ST_FULL = c_state_full
  } arb_state_e;

  // All-ones fill; consumers slice off the low cnt_bits for their ceiling.
  localparam int unsigned  c_cnt_max_bits = 64;
  localparam logic [63:0]  c_cnt_sat      = {64{1'b1}};

endpackage : mpu_pkg

`default_nettype wire

// File: rtl/mux2to1.sv
// ============================================================================
// mux2to1 : parameterised 2:1 payload multiplexer (sel=0 -> in0, sel=1 -> in1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux2to1 #(
  parameter int num_bits = 8
) (
  input  logic [num_bits-1:0] in0,
  input  logic [num_bits-1:0] in1,
  input  logic                sel,
  output logic [num_bits-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule : mux2to1

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ============================================================================
// mux_arbiter : 2-requester round-robin arbiter feeding a 1-deep output register.
// Optional grant counters enabled by defining ARB_STATS_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module mux_arbiter
  import mpu_pkg::*;
#(
  parameter int num_bits = 8
`ifdef ARB_STATS_EN
  , parameter int cnt_bits = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in0_valid,
  input  logic [num_bits-1:0] in0_data,
  output logic                in0_ready,
  input  logic                in1_valid,
  input  logic [num_bits-1:0] in1_data,
  output logic                in1_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [num_bits-1:0] out_data,
  output logic                out_src
`ifdef ARB_STATS_EN
  , output logic [cnt_bits-1:0] grant_cnt0
  , output logic [cnt_bits-1:0] grant_cnt1
`endif
);

  arb_state_e          state_q, state_d;
  logic [num_bits-1:0] out_data_q, out_data_d;
  logic                out_src_q, out_src_d;
  logic                last_grant_q, last_grant_d;

  logic                slot_free;
  logic                grant;
  logic                grant_idx;
  logic [num_bits-1:0] mux_data;

  // Grant decision uses only valids, state, out_ready and last_grant.
  always_comb begin
    slot_free = (state_q == ST_IDLE) || out_ready;
    grant_idx = (in0_valid && in1_valid) ? ~last_grant_q : in1_valid;
    grant     = slot_free && (in0_valid || in1_valid) && !rst;
    in0_ready = grant && !grant_idx;
    in1_ready = grant &&  grant_idx;
  end

  mux2to1 #(
    .num_bits (num_bits)
  ) u_mux (
    .in0 (in0_data),
    .in1 (in1_data),
    .sel (grant_idx),
    .out (mux_data)
  );

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      state_d      = ST_FULL;
      out_data_d   = mux_data;
      out_src_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARB_STATS_EN
  localparam logic [cnt_bits-1:0] c_cnt_max = c_cnt_sat[cnt_bits-1:0];

  logic [cnt_bits-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [cnt_bits-1:0] grant_cnt1_q, grant_cnt1_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (in0_ready && grant_cnt0_q != c_cnt_max) grant_cnt0_d = grant_cnt0_q + 1'b1;
    if (in1_ready && grant_cnt1_q != c_cnt_max) grant_cnt1_d = grant_cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule : mux_arbiter

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// ============================================================================
// tb_mux_arbiter : directed self-checking bench for mux_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_src;
`ifdef ARB_STATS_EN
  logic [3:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter #(
    .num_bits (8)
`ifdef ARB_STATS_EN
    , .cnt_bits (4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef ARB_STATS_EN
    , .grant_cnt0 (grant_cnt0)
    , .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00; out_ready = 1'b0;
    tick(); tick();

    // Reset state; readies forced low while rst is high even with a request.
    in0_valid = 1'b1; in1_valid = 1'b1; #1;
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_src",   out_src,   0);
`ifdef ARB_STATS_EN
    check("rst_cnt0", grant_cnt0, 0);
    check("rst_cnt1", grant_cnt1, 0);
`endif

    // Single request from in0, 1-cycle latency.
    in1_valid = 1'b0; in0_data = 8'h00; out_ready = 1'b1; tick();
    rst = 1'b0; #1;
    check("c0_in0_ready", in0_ready, 1);
    check("c0_in1_ready", in1_ready, 0);
    tick();
    in0_valid = 1'b0; #1;
    check("c1_out_valid", out_valid, 1);
    check("c1_out_data",  out_data,  8'h00);
    check("c1_out_src",   out_src,   0);
    tick();
    check("drain_out_valid", out_valid, 0);
    tick();
    check("idle_hold_valid", out_valid, 0);

    // Reset so in0 wins the first tie, then continuous round-robin.
    rst = 1'b1; tick(); rst = 1'b0;
    in0_valid = 1'b1; in0_data = 8'hAA;
    in1_valid = 1'b1; in1_data = 8'h55; out_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_in0_ready", in0_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_in1_ready", in1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check("rr_out_valid", out_valid, 1);
      check("rr_out_data",  out_data,  (i % 2 == 0) ? 8'hAA : 8'h55);
      check("rr_out_src",   out_src,   (i % 2 == 0) ? 0 : 1);
    end

    // Load FF (last grant was in1, only in0 valid anyway), then stall 5 cycles.
    in1_valid = 1'b0; in0_data = 8'hFF; tick();
    check("ff_load_data", out_data, 8'hFF);
    in1_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in0_ready", in0_ready, 0);
      check("stall_in1_ready", in1_ready, 0);
      tick();
      check("stall_out_data",  out_data,  8'hFF);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_src",   out_src,   0);
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1; tick();
    check("release_drain", out_valid, 0);

    // Tie with last_grant=0 goes to in1; then reset while FULL with pending requests.
    in0_valid = 1'b1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_data = 8'h22; out_ready = 1'b0; #1;
    check("tie_in1_ready", in1_ready, 1);
    tick();
    check("full_out_data", out_data, 8'h22);
    check("full_out_src",  out_src,  1);
    rst = 1'b1; #1;
    check("rstfull_in0_ready", in0_ready, 0);
    check("rstfull_in1_ready", in1_ready, 0);
    tick();
    check("rstfull_out_valid", out_valid, 0);
    check("rstfull_out_data",  out_data,  0);
    rst = 1'b0; out_ready = 1'b1; #1;
    check("post_rst_in0_ready", in0_ready, 1);
    check("post_rst_in1_ready", in1_ready, 0);
    tick();
    check("post_rst_out_data", out_data, 8'h11);
    check("post_rst_out_src",  out_src,  0);

`ifdef ARB_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt1", grant_cnt1, 4'hF);
    check("sat_cnt0", grant_cnt0, 4'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_arbiter

`default_nettype wire

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter num_bits, default 8, giving the data width of each requester and of the output.
REQ-002 SHALL have parameter cnt_bits, default 16, giving the width of the grant counters (only with ARB_STATS_EN).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have ports in0_valid / in1_valid, input, 1, indicating that the requester offers data.
REQ-006 SHALL have ports in0_data / in1_data, input, num_bits, the requester payloads.
REQ-007 SHALL have ports in0_ready / in1_ready, output, 1, indicating that the requester's payload is accepted this cycle.
REQ-008 SHALL have port out_valid, output, 1, indicating that out_data holds an unconsumed word.
REQ-009 SHALL have port out_ready, input, 1, indicating that the downstream consumer takes the word this cycle.
REQ-010 SHALL have port out_data, output, num_bits, the registered granted payload.
REQ-011 SHALL have port out_src, output, 1, giving the requester index of the current out_data.
REQ-012 SHALL have ports grant_cnt0 / grant_cnt1, output, cnt_bits, the per-requester accept counts (only with ARB_STATS_EN).

Function
REQ-013 SHALL transfer a word on a port when that port's valid and ready are both 1 at a rising clk edge.
REQ-014 SHALL implement the FSM states IDLE (output register empty) and FULL (output register holds a word).
REQ-015 SHALL compute "slot free" as IDLE, or FULL with out_ready=1.
REQ-016 SHALL assert at most one of in0_ready / in1_ready per cycle, and only when the slot is free.
REQ-017 SHALL grant the single valid requester when only one requester is valid.
REQ-018 SHALL grant the requester not equal to last_grant when both requesters are valid (round-robin).
REQ-019 SHALL derive in_ready combinationally from the valids, the FSM state, out_ready and last_grant, with no combinational path from in*_data.
REQ-020 SHALL, on a grant, load the selected payload into out_data through the 2:1 mux, load the granted index into out_src and last_grant, and set out_valid=1 on the next edge (1-cycle latency).
REQ-021 SHALL take the transitions IDLE->FULL on a grant; FULL->IDLE on out_ready=1 with no grant; FULL->FULL on out_ready=1 with a grant (back-to-back, no bubble); FULL->FULL holding out_data/out_src on out_ready=0.
REQ-022 SHALL hold out_data, out_src and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL perform no grant and change no state when no requester is valid in IDLE.
REQ-024 SHALL not update last_grant when no grant occurs.

Reset
REQ-025 SHALL, on rst=1 at an edge, set the FSM to IDLE, out_valid=0, out_data=0, out_src=0, last_grant=1 (requester 0 wins the first tie), and grant counters=0.
REQ-026 SHALL force in0_ready=in1_ready=0 while rst=1; a word held mid-operation is discarded.

Configuration
REQ-027 SHALL, with ARB_STATS_EN defined, provide grant_cnt0/grant_cnt1, each incrementing by 1 per accept of its requester and saturating at all-ones.
REQ-028 SHALL, without ARB_STATS_EN, omit the grant_cnt ports and the counter logic; all other behaviour is identical.

Structure
REQ-029 SHALL take the FSM state encodings (IDLE=0, FULL=1) and the counter saturation constant from the shared package mpu_pkg.
REQ-030 SHALL perform payload selection by instantiating the existing mux2to1 (num_bits passed through), with sel driven by the grant index.

Verification
REQ-031 SHALL cover: reset, then in0_valid=1, in0_data=8'h00, out_ready=1 -> in0_ready=1 in cycle 0; out_valid=1, out_data=8'h00, out_src=0 in cycle 1.
REQ-032 SHALL cover: both valid continuously with in0=8'hAA, in1=8'h55, out_ready=1 -> outputs alternate AA,55,AA,55 with out_src 0,1,0,1 and no idle cycles.
REQ-033 SHALL cover: out_ready=0 for 5 cycles while FULL with 8'hFF -> both in*_ready=0, out_data remains 8'hFF; release -> drains next cycle.
REQ-034 SHALL cover: rst asserted while FULL with pending requests -> next cycle out_valid=0, ready outputs 0; after release, requester 0 wins the first tie.
REQ-035 SHALL cover: with ARB_STATS_EN and cnt_bits=4, 20 accepts of in1 -> grant_cnt1=15 (saturated), grant_cnt0=0.
